// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DELIVER  = 2'd2,
        CHANGE   = 2'd3
    } vm_state_t;

    localparam int unsigned MAX_PRODUCTS  = 8;
    localparam int unsigned MAX_PRICE_W   = 16;
    localparam int unsigned PRICE_TABLE_W = MAX_PRODUCTS * MAX_PRICE_W;

    // Default table for four products: entry 0 in the low byte.
    localparam logic [31:0] DEFAULT_PRICES = {8'd9, 8'd7, 8'd5, 8'd3};

    // Extract entry idx of a packed price table whose entries are price_w bits wide.
    function automatic logic [MAX_PRICE_W-1:0] price_of(
        input logic [PRICE_TABLE_W-1:0] table_bits,
        input int unsigned              idx,
        input int unsigned              price_w
    );
        logic [PRICE_TABLE_W-1:0] shifted;
        logic [MAX_PRICE_W:0]     mask;
        shifted = table_bits >> (idx * price_w);
        mask    = (17'd1 << price_w) - 17'd1;
        return shifted[MAX_PRICE_W-1:0] & mask[MAX_PRICE_W-1:0];
    endfunction

endpackage

// File: rtl/vending_machine_mc_timer.sv
// Loadable down-counter with a combinational done flag; times DISPENSE and DELIVER.
module vm_cycle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;

    // Load has priority; otherwise count down to zero and hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/vending_machine_mc.sv
// Multi-product vending controller: saturating credit, per-product price and
// stock, timed dispense/deliver, chunked change payout.
// Optional feature: define VM_REFUND_EN to add refund_in (credit payout from IDLE).
module vending_machine_mc
    import vending_pkg::*;
#(
    parameter int unsigned NUM_PRODUCTS   = 4,
    parameter int unsigned CREDIT_W       = 16,
    parameter int unsigned COIN_W         = 4,
    parameter int unsigned PRICE_W        = 8,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES =
        (NUM_PRODUCTS*PRICE_W)'(DEFAULT_PRICES),
    parameter int unsigned MAX_CREDIT     = 200,
    parameter int unsigned DISP_CYCLES    = 10,
    parameter int unsigned DELIVER_CYCLES = 10,
    parameter int unsigned CHANGE_MAX     = 7
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    coin_valid,
    input  logic [COIN_W-1:0]                       coin_in,
    input  logic [NUM_PRODUCTS-1:0]                 button_in,
    input  logic [NUM_PRODUCTS-1:0]                 stock_empty,
`ifdef VM_REFUND_EN
    input  logic                                    refund_in,
`endif
    output logic [CREDIT_W-1:0]                     credit_out,
    output logic                                    disp_out,
    output logic [$clog2(NUM_PRODUCTS+1)-1:0]       beverage_out,
    output logic [$clog2(CHANGE_MAX+1)-1:0]         change_out,
    output logic                                    change_valid,
    output logic                                    coin_reject,
    output logic                                    deny_out,
    output logic                                    busy
);

    localparam int unsigned IDX_W   = $clog2(NUM_PRODUCTS);
    localparam int unsigned BEV_W   = $clog2(NUM_PRODUCTS + 1);
    localparam int unsigned CHG_W   = $clog2(CHANGE_MAX + 1);
    localparam int unsigned TMR_MAX = (DISP_CYCLES > DELIVER_CYCLES) ? DISP_CYCLES : DELIVER_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CREDIT_W:0]   MAX_SUM      = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] CHANGE_MAX_C = CREDIT_W'(CHANGE_MAX);

    vm_state_t           state_q, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [IDX_W-1:0]    sel_q, sel_nxt;

    logic                disp_nxt;
    logic [BEV_W-1:0]    bev_nxt;
    logic [CHG_W-1:0]    change_nxt;
    logic                change_valid_nxt;
    logic                coin_rej_nxt;
    logic                deny_nxt;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                tmr_en;
    logic                tmr_done_c;

    logic [CREDIT_W:0]   coin_sum;
    logic [IDX_W-1:0]    btn_idx;
    logic                sel_ok;
    logic                refund_req;
    logic [CREDIT_W-1:0] chunk_cur;
    logic [CREDIT_W-1:0] chunk_nxt;
    logic [CREDIT_W-1:0] price_tab [NUM_PRODUCTS];

    // Unpack the price table into zero-extended per-product prices.
    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_price
        assign price_tab[g] = CREDIT_W'(price_of(PRICE_TABLE_W'(PRICES), g, PRICE_W));
    end

`ifdef VM_REFUND_EN
    assign refund_req = refund_in;
`else
    assign refund_req = 1'b0;
`endif

    // Shared cycle timer: loaded on entry to DISPENSE and DELIVER.
    vm_cycle_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .done_c   (tmr_done_c)
    );

    assign tmr_en = (state_q == DISPENSE) || (state_q == DELIVER);

    // Button decode: index of the highest pressed button, validity of the selection.
    always_comb begin
        btn_idx = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (button_in[i]) begin
                btn_idx = IDX_W'(i);
            end
        end
        sel_ok = $onehot(button_in)
              && !stock_empty[btn_idx]
              && (credit_q >= price_tab[btn_idx]);
    end

    assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_in);
    assign chunk_cur = (credit_q > CHANGE_MAX_C) ? CHANGE_MAX_C : credit_q;

    // Next state, next credit/selection and next registered output values.
    always_comb begin
        state_nxt        = state_q;
        credit_nxt       = credit_q;
        sel_nxt          = sel_q;
        tmr_load         = 1'b0;
        tmr_load_val     = '0;
        coin_rej_nxt     = 1'b0;
        deny_nxt         = 1'b0;

        case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_sum <= MAX_SUM) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_rej_nxt = 1'b1;
                    end
                end
                if (refund_req && (credit_q != '0)) begin
                    state_nxt = CHANGE;
                end else if (button_in != '0) begin
                    if (sel_ok) begin
                        state_nxt    = DISPENSE;
                        sel_nxt      = btn_idx;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(DISP_CYCLES - 1);
                    end else begin
                        deny_nxt = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                if (tmr_done_c) begin
                    credit_nxt   = (credit_q >= price_tab[sel_q]) ? (credit_q - price_tab[sel_q]) : '0;
                    state_nxt    = DELIVER;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(DELIVER_CYCLES - 1);
                end
            end
            DELIVER: begin
                if (tmr_done_c) begin
                    state_nxt = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                credit_nxt = credit_q - chunk_cur;
                if (credit_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (coin_valid && (state_q != IDLE)) begin
            coin_rej_nxt = 1'b1;
        end

        chunk_nxt        = (credit_nxt > CHANGE_MAX_C) ? CHANGE_MAX_C : credit_nxt;
        disp_nxt         = (state_nxt == DISPENSE);
        bev_nxt          = (state_nxt == DELIVER) ? (BEV_W'(sel_nxt) + BEV_W'(1)) : '0;
        change_valid_nxt = (state_nxt == CHANGE);
        change_nxt       = (state_nxt == CHANGE) ? CHG_W'(chunk_nxt) : '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            sel_q        <= '0;
            disp_out     <= 1'b0;
            beverage_out <= '0;
            change_out   <= '0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            deny_out     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            credit_q     <= credit_nxt;
            sel_q        <= sel_nxt;
            disp_out     <= disp_nxt;
            beverage_out <= bev_nxt;
            change_out   <= change_nxt;
            change_valid <= change_valid_nxt;
            coin_reject  <= coin_rej_nxt;
            deny_out     <= deny_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

    assign credit_out = credit_q;

endmodule

// File: tb/tb_vending_machine_mc.sv
// Self-checking bench for vending_machine_mc with a transaction-level model.
module tb_vending_machine_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_in = '0;
    logic [3:0] button_in = '0;
    logic [3:0] stock_empty = '0;
`ifdef VM_REFUND_EN
    logic       refund_in = 1'b0;
`endif
    logic [15:0] credit_out;
    logic        disp_out;
    logic [2:0]  beverage_out;
    logic [2:0]  change_out;
    logic        change_valid;
    logic        coin_reject;
    logic        deny_out;
    logic        busy;

    int checks = 0;
    int failures = 0;

    vending_machine_mc dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_in      (coin_in),
        .button_in    (button_in),
        .stock_empty  (stock_empty),
`ifdef VM_REFUND_EN
        .refund_in    (refund_in),
`endif
        .credit_out   (credit_out),
        .disp_out     (disp_out),
        .beverage_out (beverage_out),
        .change_out   (change_out),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .deny_out     (deny_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int credit;
        int disp;
        int bev;
        int chg;
        int cv;
        int rej;
        int deny;
        int busy;
    } exp_t;

    localparam int PRICE [4] = '{3, 5, 7, 9};

    exp_t cur;
    exp_t plan[$];
    int   m_credit;

    function automatic exp_t blank();
        exp_t e;
        e.credit = 0; e.disp = 0; e.bev = 0; e.chg = 0;
        e.cv = 0; e.rej = 0; e.deny = 0; e.busy = 0;
        return e;
    endfunction

    task automatic push_payout(input int amount);
        int c;
        exp_t e;
        c = amount;
        while (c > 0) begin
            e = blank();
            e.credit = c;
            e.chg = (c > 7) ? 7 : c;
            e.cv = 1;
            e.busy = 1;
            plan.push_back(e);
            c -= e.chg;
        end
    endtask

    // Each clock: outputs expected in the following cycle, from the rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            plan.delete();
            m_credit = 0;
            cur = blank();
        end else begin
            exp_t nx;
            exp_t e;
            int   oc, c, idx, nb, p;
            bit   rej, deny, refund;
            rej = 0; deny = 0; refund = 0;
            if (cur.busy != 0) begin
                if (coin_valid) rej = 1;
            end else begin
                oc = m_credit;
                c  = oc;
                if (coin_valid) begin
                    if (c + int'(coin_in) <= 200) c += int'(coin_in);
                    else rej = 1;
                end
                m_credit = c;
`ifdef VM_REFUND_EN
                refund = refund_in && (oc > 0);
`endif
                if (refund) begin
                    push_payout(c);
                    m_credit = 0;
                end else if (button_in != 0) begin
                    nb = $countones(button_in);
                    idx = 0;
                    for (int i = 0; i < 4; i++) if (button_in[i]) idx = i;
                    p = PRICE[idx];
                    if (nb == 1 && !stock_empty[idx] && oc >= p) begin
                        for (int k = 0; k < 10; k++) begin
                            e = blank(); e.credit = c; e.disp = 1; e.busy = 1;
                            plan.push_back(e);
                        end
                        for (int k = 0; k < 10; k++) begin
                            e = blank(); e.credit = c - p; e.bev = idx + 1; e.busy = 1;
                            plan.push_back(e);
                        end
                        push_payout(c - p);
                        m_credit = 0;
                    end else begin
                        deny = 1;
                    end
                end
            end
            if (plan.size() > 0) nx = plan.pop_front();
            else begin
                nx = blank();
                nx.credit = m_credit;
            end
            nx.rej = rej;
            nx.deny = deny;
            cur = nx;
        end
    end

    // Compare DUT against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            chk("cmp_credit", int'(credit_out), cur.credit);
            chk("cmp_disp", int'(disp_out), cur.disp);
            chk("cmp_bev", int'(beverage_out), cur.bev);
            chk("cmp_change", int'(change_out), cur.chg);
            chk("cmp_change_valid", int'(change_valid), cur.cv);
            chk("cmp_coin_reject", int'(coin_reject), cur.rej);
            chk("cmp_deny", int'(deny_out), cur.deny);
            chk("cmp_busy", int'(busy), cur.busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    int disp_cnt, bev_cnt, deny_cnt, chg_sum;
    int chg_q[$];

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_in = 4'(v);
        @(negedge clk);
        coin_valid = 1'b0;
        coin_in = '0;
    endtask

    task automatic press(input logic [3:0] b);
        button_in = b;
        @(negedge clk);
        button_in = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_credit"}, int'(credit_out), 0);
        chk({tag, "_disp"}, int'(disp_out), 0);
        chk({tag, "_bev"}, int'(beverage_out), 0);
        chk({tag, "_change"}, int'(change_out), 0);
        chk({tag, "_cv"}, int'(change_valid), 0);
        chk({tag, "_rej"}, int'(coin_reject), 0);
        chk({tag, "_deny"}, int'(deny_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Observe from the current cycle until busy drops, bounded.
    task automatic run_until_idle(input string tag, input int bev_id);
        int n;
        n = 0;
        disp_cnt = 0; bev_cnt = 0; deny_cnt = 0; chg_sum = 0;
        chg_q.delete();
        while (busy && n < 1000) begin
            if (disp_out) disp_cnt++;
            if (int'(beverage_out) == bev_id) bev_cnt++;
            if (deny_out) deny_cnt++;
            if (change_valid) begin
                chg_q.push_back(int'(change_out));
                chg_sum += int'(change_out);
            end
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, int'(busy), 0);
    endtask

    function automatic int chg_at(input int i);
        return (i < chg_q.size()) ? chg_q[i] : -1;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // Basic vend with change
        coin(5); coin(5);
        chk("s1_credit10", int'(credit_out), 10);
        press(4'b0001);
        chk("s1_disp_first", int'(disp_out), 1);
        run_until_idle("s1", 1);
        chk("s1_disp_cycles", disp_cnt, 10);
        chk("s1_bev_cycles", bev_cnt, 10);
        chk("s1_pulses", chg_q.size(), 1);
        chk("s1_chg0", chg_at(0), 7);
        chk("s1_credit_end", int'(credit_out), 0);

        // Change chunking
        repeat (4) coin(5);
        chk("s2_credit20", int'(credit_out), 20);
        press(4'b1000);
        run_until_idle("s2", 4);
        chk("s2_bev_cycles", bev_cnt, 10);
        chk("s2_pulses", chg_q.size(), 2);
        chk("s2_chg0", chg_at(0), 7);
        chk("s2_chg1", chg_at(1), 4);
        chk("s2_credit_end", int'(credit_out), 0);

        // Denials
        coin(4);
        press(4'b0100);
        chk("d1_deny", int'(deny_out), 1);
        chk("d1_credit", int'(credit_out), 4);
        @(negedge clk);
        chk("d1_deny_one_cycle", int'(deny_out), 0);
        stock_empty = 4'b0010;
        coin(1);
        press(4'b0010);
        chk("d2_deny_stock", int'(deny_out), 1);
        stock_empty = '0;
        press(4'b0011);
        chk("d3_deny_multi", int'(deny_out), 1);
        chk("d3_not_busy", int'(busy), 0);
        press(4'b0010);
        run_until_idle("d4", 2);
        chk("d4_bev_cycles", bev_cnt, 10);
        chk("d4_no_change", chg_q.size(), 0);
        chk("d4_credit_end", int'(credit_out), 0);

        // Saturation and coins while busy
        repeat (13) coin(15);
        coin(3);
        chk("sat_credit198", int'(credit_out), 198);
        coin(5);
        chk("sat_reject", int'(coin_reject), 1);
        chk("sat_credit_hold", int'(credit_out), 198);
        coin(2);
        chk("sat_credit200", int'(credit_out), 200);
        press(4'b1000);
        coin(3);
        chk("busy_reject", int'(coin_reject), 1);
        chk("busy_credit", int'(credit_out), 200);
        run_until_idle("sat", 4);
        chk("sat_pulses", chg_q.size(), 28);
        chk("sat_chg_sum", chg_sum, 191);
        chk("sat_credit_end", int'(credit_out), 0);

        // Coin and button together
        coin(2);
        coin_valid = 1'b1; coin_in = 4'd3; button_in = 4'b0001;
        @(negedge clk);
        coin_valid = 1'b0; coin_in = '0; button_in = '0;
        chk("sim_deny", int'(deny_out), 1);
        chk("sim_credit5", int'(credit_out), 5);
        press(4'b0010);
        run_until_idle("sim", 2);

        // Reset during DELIVER
        coin(5);
        press(4'b0001);
        repeat (11) @(negedge clk);
        chk("rst_in_deliver_bev", int'(beverage_out), 1);
        chk("rst_in_deliver_credit", int'(credit_out), 2);
        #2 rst = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("after_reset");

`ifdef VM_REFUND_EN
        // Refund wins over a simultaneous button
        coin(5); coin(4);
        refund_in = 1'b1; button_in = 4'b0001;
        @(negedge clk);
        refund_in = 1'b0; button_in = '0;
        chk("ref_first_cv", int'(change_valid), 1);
        chk("ref_no_deny", int'(deny_out), 0);
        run_until_idle("ref", 1);
        chk("ref_pulses", chg_q.size(), 2);
        chk("ref_chg0", chg_at(0), 7);
        chk("ref_chg1", chg_at(1), 2);
        chk("ref_no_disp", disp_cnt, 0);
        chk("ref_no_deny_any", deny_cnt, 0);
        chk("ref_credit_end", int'(credit_out), 0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
